// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the MIPS pipeline sequencing controller.
//   - FSM state encoding (RUN, FLUSH)
//   - TUSE/TNEW field width and the "operand not used" TUSE code
//   - default mult/div busy lengths
//   - src_haz(): data-hazard test for one source operand of the D instruction
package pipe_pkg;

  localparam int TW = 2;
  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  // A source stalls when a producer in E or M targets it and will not have
  // the value ready by the time D needs it. TUSE_NONE (3) can never be
  // exceeded by a 2-bit tnew, so unused operands never stall.
  function automatic logic src_haz(
    input logic [4:0]    x,
    input logic [TW-1:0] tuse,
    input logic [4:0]    waE,
    input logic [TW-1:0] tnewE,
    input logic [4:0]    waM,
    input logic [TW-1:0] tnewM
  );
    return (x != 5'd0) &&
           (((x == waE) && (tnewE > tuse)) ||
            ((x == waM) && (tnewM > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: occupancy counter for the multi-cycle mult/div unit.
// Ports:
//   clk, rst   - clock, async active-high reset (clears the counter)
//   start      - accept a new op this cycle (already qualified by the caller)
//   isDiv      - 1 = div/divu length, 0 = mult/multu length
//   busy       - counter nonzero
// A start is ignored while an op is still counting; the counter otherwise
// decrements to 0 and holds there.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic isDiv,
  output logic busy
);

  localparam logic [CNT_W-1:0] MC = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DC = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (start && (cnt == '0))   cnt <= isDiv ? DC : MC;
    else if (cnt != '0)              cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall / bubble / flush sequencing for the five-stage MIPS pipe.
// Ports:
//   clk, rst            - clock, async active-high reset
//   rsD, rtD            - D-stage source register numbers
//   tuseRsD, tuseRtD    - cycles until D needs rs/rt (3 = unused)
//   waE, waM            - E/M destination register (0 = no write)
//   tnewE, tnewM        - cycles until E/M produce their result
//   mdUseD              - D holds a HI/LO or mult/div instruction
//   mdStartE, mdIsDivE  - mult/div op in E and its kind
//   excReq              - exception/interrupt request taken at M
//   stallF, stallD      - hold PC and F/D register (combinational)
//   clrE                - bubble into D/E (combinational)
//   DEMWclr, excPcSel   - flush D/E/M/W and vector to handler (registered)
//   mdBusy              - mult/div unit occupied
// Optional: PIPE_CTRL_PERF_EN adds stallCnt / flushCnt (32-bit, wrapping).
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    rsD,
  input  logic [4:0]    rtD,
  input  logic [TW-1:0] tuseRsD,
  input  logic [TW-1:0] tuseRtD,
  input  logic [4:0]    waE,
  input  logic [4:0]    waM,
  input  logic [TW-1:0] tnewE,
  input  logic [TW-1:0] tnewM,
  input  logic          mdUseD,
  input  logic          mdStartE,
  input  logic          mdIsDivE,
  input  logic          excReq,
  output logic          stallF,
  output logic          stallD,
  output logic          clrE,
  output logic          DEMWclr,
  output logic          excPcSel,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]   stallCnt,
  output logic [31:0]   flushCnt,
`endif
  output logic          mdBusy
);

  pipe_state_e state;

  // Gating with rst keeps every output low for the whole reset assertion,
  // not just after the next edge.
  logic run;
  assign run = (state == RUN) && !rst;

  logic haz, md_stall, stall;
  assign haz = src_haz(rsD, tuseRsD, waE, tnewE, waM, tnewM) ||
               src_haz(rtD, tuseRtD, waE, tnewE, waM, tnewM);
  assign md_stall = mdUseD && (mdBusy || mdStartE);
  assign stall    = run && (haz || md_stall);

  assign stallF = stall;
  assign stallD = stall;
  assign clrE   = stall;

  // An op in E alongside an exception is younger than the faulting
  // instruction and gets flushed, so it must not occupy the unit.
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (run && mdStartE && !excReq),
    .isDiv (mdIsDivE),
    .busy  (mdBusy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      DEMWclr  <= 1'b0;
      excPcSel <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (excReq) begin
            state    <= FLUSH;
            DEMWclr  <= 1'b1;
            excPcSel <= 1'b1;
          end else begin
            DEMWclr  <= 1'b0;
            excPcSel <= 1'b0;
          end
        end
        default: begin
          // One flush cycle only; a still-high excReq is re-taken from RUN.
          state    <= RUN;
          DEMWclr  <= 1'b0;
          excPcSel <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall)                        stallCnt <= stallCnt + 32'd1;
      if ((state == RUN) && excReq)     flushCnt <= flushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Table of hazard vectors,
// hand sequences for mult/div, exception and reset corners, then random
// stimulus against a cycle-numbered reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, waE, waM;
  logic [1:0] tuseRsD, tuseRtD, tnewE, tnewM;
  logic       mdUseD, mdStartE, mdIsDivE, excReq;
  logic       stallF, stallD, clrE, DEMWclr, excPcSel, mdBusy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt, flushCnt;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .tuseRsD(tuseRsD),
    .tuseRtD(tuseRtD), .waE(waE), .waM(waM), .tnewE(tnewE), .tnewM(tnewM),
    .mdUseD(mdUseD), .mdStartE(mdStartE), .mdIsDivE(mdIsDivE),
    .excReq(excReq), .stallF(stallF), .stallD(stallD), .clrE(clrE),
    .DEMWclr(DEMWclr), .excPcSel(excPcSel),
`ifdef PIPE_CTRL_PERF_EN
    .stallCnt(stallCnt), .flushCnt(flushCnt),
`endif
    .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // outputs packed as {stallF, stallD, clrE, DEMWclr, excPcSel, mdBusy}
  function automatic logic [5:0] outs();
    return {stallF, stallD, clrE, DEMWclr, excPcSel, mdBusy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rsD = 0; rtD = 0; waE = 0; waM = 0;
    tuseRsD = 2'd3; tuseRtD = 2'd3; tnewE = 0; tnewM = 0;
    mdUseD = 0; mdStartE = 0; mdIsDivE = 0; excReq = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Time is a cycle number; the mult/div unit is busy through busy_until,
  // and the single flush cycle is the one numbered flush_at.
  int cyc, busy_until, flush_at;

  function automatic bit ref_haz(input int x, input int tuse);
    if (x == 0 || tuse == 3) return 0;
    return (x == waE && tnewE > tuse) || (x == waM && tnewM > tuse);
  endfunction

  function automatic logic [5:0] ref_out();
    bit fl, busy, st;
    fl   = (cyc == flush_at);
    busy = (cyc <= busy_until);
    st   = !fl && (ref_haz(rsD, tuseRsD) || ref_haz(rtD, tuseRtD) ||
                   (mdUseD && (busy || mdStartE)));
    return {st, st, st, fl, fl, busy};
  endfunction

  task automatic ref_advance();
    bit fl, busy;
    fl   = (cyc == flush_at);
    busy = (cyc <= busy_until);
    if (!fl && excReq) flush_at = cyc + 1;
    if (!fl && mdStartE && !excReq && !busy)
      busy_until = cyc + (mdIsDivE ? 10 : 5);
    cyc++;
  endtask

  // ---------------- hazard vector table ----------------
  typedef struct {
    logic [4:0] rs, rt, we, wm;
    logic [1:0] urs, urt, ne, nm;
    logic       st;
  } hv_t;

  hv_t tbl[9];

  initial begin
    rst = 1'b1;
    idle_inputs();

    tbl[0] = '{rs:5, rt:0, we:5, wm:0, urs:1, urt:3, ne:2, nm:0, st:1}; // load-use
    tbl[1] = '{rs:0, rt:0, we:5, wm:0, urs:1, urt:3, ne:2, nm:0, st:0}; // $0 never stalls
    tbl[2] = '{rs:0, rt:7, we:0, wm:7, urs:3, urt:0, ne:0, nm:0, st:0}; // forwardable from M
    tbl[3] = '{rs:0, rt:7, we:0, wm:7, urs:3, urt:1, ne:0, nm:2, st:1}; // M too late
    tbl[4] = '{rs:5, rt:0, we:5, wm:0, urs:3, urt:3, ne:3, nm:0, st:0}; // tuse none
    tbl[5] = '{rs:5, rt:0, we:5, wm:0, urs:1, urt:3, ne:1, nm:0, st:0}; // tnew == tuse
    tbl[6] = '{rs:0, rt:9, we:9, wm:0, urs:3, urt:0, ne:1, nm:0, st:1}; // rt vs E
    tbl[7] = '{rs:4, rt:0, we:5, wm:0, urs:0, urt:3, ne:3, nm:0, st:0}; // different reg
    tbl[8] = '{rs:0, rt:0, we:0, wm:0, urs:0, urt:0, ne:3, nm:3, st:0}; // all zero regs

    // reset state, checked while rst is still asserted
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // combinational hazard table
    foreach (tbl[i]) begin
      @(negedge clk);
      rsD = tbl[i].rs; rtD = tbl[i].rt; waE = tbl[i].we; waM = tbl[i].wm;
      tuseRsD = tbl[i].urs; tuseRtD = tbl[i].urt; tnewE = tbl[i].ne; tnewM = tbl[i].nm;
      #1 chk($sformatf("hazard_vec%0d", i), 32'(outs()), 32'({{3{tbl[i].st}}, 3'b000}));
    end

    // div then mflo held in D: stall cycles 0..10, release at 11
    @(negedge clk);
    idle_inputs();
    mdStartE = 1; mdIsDivE = 1; mdUseD = 1;
    #1 chk("div_c0_stall", 32'(outs()), 32'b111000);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      mdStartE = 0;
      #1 chk($sformatf("div_c%0d", k), 32'(outs()), 32'b111001);
    end
    @(negedge clk);
    #1 chk("div_c11_release", 32'(outs()), 32'b000000);

    // single-cycle exception; hazard inputs present during FLUSH
    @(negedge clk);
    idle_inputs();
    excReq = 1;
    #1 chk("exc_req_cycle", 32'(outs()), 32'b000000);
    @(negedge clk);
    excReq = 0;
    rsD = 5; waE = 5; tnewE = 2; tuseRsD = 1; mdUseD = 1; mdStartE = 1;
    #1 chk("exc_flush_cycle", 32'(outs()), 32'b000110);
    @(negedge clk);
    idle_inputs();
    #1 chk("exc_after_flush", 32'(outs()), 32'b000000);

    // stall and excReq together: stall now, flush next
    @(negedge clk);
    rsD = 5; waE = 5; tnewE = 2; tuseRsD = 1; excReq = 1;
    #1 chk("stall_wins", 32'(outs()), 32'b111000);
    @(negedge clk);
    idle_inputs();
    #1 chk("flush_follows", 32'(outs()), 32'b000110);

    // mdStartE with excReq: no load
    @(negedge clk);
    mdStartE = 1; excReq = 1;
    #1 chk("start_exc_cycle", 32'(outs()), 32'b000000);
    @(negedge clk);
    idle_inputs();
    #1 chk("start_exc_no_busy", 32'(outs()), 32'b000110);
    @(negedge clk);
    #1 chk("start_exc_no_busy2", 32'(outs()), 32'b000000);

    // mult keeps counting through a flush: busy exactly 5 cycles
    @(negedge clk);
    mdStartE = 1; mdIsDivE = 0;
    #1 chk("mult_start", 32'(outs()), 32'b000000);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 2) excReq = 1;
      #1 chk($sformatf("mult_c%0d", k), 32'(outs()),
             32'({3'b000, (k == 3), (k == 3), (k <= 5)}));
    end

    // random stimulus against the reference model
    do_reset();
    cyc = 0; busy_until = -1; flush_at = -1;
    for (int n = 0; n < 400; n++) begin
      rsD      = 5'($urandom_range(0, 3));
      rtD      = 5'($urandom_range(0, 3));
      waE      = 5'($urandom_range(0, 3));
      waM      = 5'($urandom_range(0, 3));
      tuseRsD  = 2'($urandom);
      tuseRtD  = 2'($urandom);
      tnewE    = 2'($urandom);
      tnewM    = 2'($urandom);
      mdUseD   = ($urandom_range(0, 2) == 0);
      mdStartE = ($urandom_range(0, 4) == 0);
      mdIsDivE = 1'($urandom);
      excReq   = ($urandom_range(0, 9) == 0);
      #1 chk($sformatf("rand%0d", n), 32'(outs()), 32'(ref_out()));
      ref_advance();
      @(negedge clk);
    end

    // async reset in the middle of a division
    idle_inputs();
    mdStartE = 1; mdIsDivE = 1;
    @(negedge clk);
    mdStartE = 0; mdUseD = 1;
    @(negedge clk);
    #1 chk("mid_div_busy", 32'(outs()), 32'b111001);
    #2 rst = 1'b1;
    rsD = 5; waE = 5; tnewE = 2; tuseRsD = 1;
    #1 chk("async_rst_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1 chk("after_rst_idle", 32'(outs()), 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    rsD = 5; waE = 5; tnewE = 2; tuseRsD = 1;
    repeat (3) @(negedge clk);
    idle_inputs();
    excReq = 1;
    @(negedge clk);
    excReq = 0;
    @(negedge clk);
    chk("perf_stallCnt", stallCnt, 32'd3);
    chk("perf_flushCnt", flushCnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencing controller for the five-stage MIPS pipeline. Each cycle it decides whether the F/D registers hold, whether the E register is cleared (bubble insert), and whether the D/E/M/W registers are flushed together on an exception. It also tracks the multi-cycle multiply/divide unit so that HI/LO consumers stall until the result exists. It sits beside the stage registers and drives their stall and clear pins, including the `DEMWclr` pin of every D/E/M/W register.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu.
- `CNT_W`, default 4: busy-counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `rsD`, `rtD` in 5 each: source register numbers of the instruction in D.
- `tuseRsD`, `tuseRtD` in 2 each: cycles until D needs rs/rt. Value 3 means "not used".
- `waE`, `waM` in 5 each: destination register in E and in M. Value 0 means no write.
- `tnewE`, `tnewM` in 2 each: cycles until E/M produce their result. Already stage-adjusted upstream.
- `mdUseD` in 1: instruction in D is a mult/div/mfhi/mflo/mthi/mtlo.
- `mdStartE` in 1: a mult/div-class instruction is in E this cycle.
- `mdIsDivE` in 1: qualifies `mdStartE`. 1 = div/divu, 0 = mult/multu.
- `excReq` in 1: CP0 exception/interrupt request, taken at M.
- `stallF`, `stallD` out 1: hold the PC and the F/D register.
- `clrE` out 1: load a bubble into the D/E register.
- `DEMWclr` out 1: flush D/E, E/M and M/W together.
- `excPcSel` out 1: next PC selects the exception handler address.
- `mdBusy` out 1: the mult/div unit is occupied.

## Operation
- FSM states: RUN, FLUSH.
  - RUN → FLUSH when `excReq`=1.
  - FLUSH → RUN unconditionally after 1 cycle.
- In FLUSH:
  - `DEMWclr`=1 and `excPcSel`=1.
  - `stallF`, `stallD` and `clrE` are forced to 0.
  - `excReq` is ignored. If it is still high on return to RUN, it is taken again.
- Data-hazard stall (RUN only), evaluated per source X ∈ {rs, rt}:
  - stall if X≠0, and (X==waE and tnewE>tuseX) or (X==waM and tnewM>tuseX).
  - tuse=3 never stalls.
- MD stall (RUN only): `mdUseD` and (`mdBusy` or `mdStartE`).
- Any stall sets `stallF`=`stallD`=`clrE`=1 in that cycle, combinationally from the inputs.
- Busy counter:
  - In RUN, when `mdStartE`=1, `excReq`=0 and the counter is 0: load MULT_CYC or DIV_CYC according to `mdIsDivE`.
  - Otherwise it decrements while nonzero and saturates at 0.
  - `mdBusy` = (counter≠0).
- `mdStartE` arriving with `excReq` in the same cycle: the E instruction is younger than the faulting one and is flushed, so no load happens.
- An exception does not cancel an operation already counting; the counter keeps decrementing through FLUSH.
- `mdStartE` while the counter is nonzero is impossible, because the D-stage MD stall prevents it. It is ignored if it occurs.

## Timing
- Reset values: state RUN, counter 0, every output 0.
- Reset mid-operation aborts the counter and FLUSH immediately (asynchronous).
- Stall and clear outputs are combinational, with zero-cycle latency from the inputs.
- `excReq` sampled at edge n produces `DEMWclr`/`excPcSel` high for exactly cycle n+1.
- Busy length: a mult started in cycle n gives `mdBusy` high for cycles n+1 .. n+MULT_CYC. The first non-stalled mfhi/mflo in D is in cycle n+MULT_CYC+1.
- Simultaneous hazard stall and `excReq` in RUN: the stall wins in the current cycle, and FLUSH follows next cycle regardless.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `stallCnt` (32-bit) and `flushCnt` (32-bit), both cleared by `rst`.
  - `stallCnt` increments each RUN cycle with `stallD`=1.
  - `flushCnt` increments on each entry into FLUSH.
  - Both counters wrap at 2^32.
- Undefined: the counters and their ports do not exist, and behaviour is otherwise identical.

## Structure
- Package `pipe_pkg` holds:
  - the state encoding (RUN, FLUSH);
  - the TUSE/TNEW width (2) and the TUSE_NONE constant (3);
  - the default MULT_CYC/DIV_CYC constants.
- Sub-module `md_busy_cnt` contains the load, decrement and saturate logic and produces `mdBusy`. The top level holds the FSM, the hazard compare and the perf counters.

## Test plan
- Load-use: waE=5, tnewE=2, rsD=5, tuseRsD=1 → `stallF`=`stallD`=`clrE`=1. Same inputs with rsD=0 → all 0.
- Forwardable case: waM=7, tnewM=0, rtD=7, tuseRtD=0 → no stall.
- Div then mflo: `mdStartE`=1 and `mdIsDivE`=1 at cycle 0, `mdUseD`=1 held → stall at cycles 0..10 and release at cycle 11.
- Exception: `excReq` for 1 cycle → `DEMWclr`=`excPcSel`=1 for exactly 1 cycle, with stall outputs 0 in that cycle.
- `mdStartE` with `excReq` in the same cycle → `mdBusy` stays 0. A mult already counting keeps `mdBusy` high through FLUSH.
- Assert `rst` mid-division: all outputs 0 and `mdBusy`=0 immediately, without waiting for an edge. With `PIPE_CTRL_PERF_EN`: 3 stall cycles plus 1 flush → `stallCnt`=3, `flushCnt`=1.
